vt57_video_dma: RTL

- Single-channel DMA/bus arbiter that shares the Radio-86RK main memory port between the CPU and the vg75 video adapter's row refresh.
- On each row request from the video side, it takes the memory bus and bursts one text row of screen bytes into the vg75 row buffer.
- Between bursts, it serves single CPU read/write cycles.
- Sits between the CPU core, the SDRAM/BRAM memory port and vg75 in the de0 top level, clocked from the 25 MHz PLL output.

---
 rtl/vt57_video_dma.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vt57_video_dma.sv
// ----------------------------------------------------------------------------
// vt57_video_dma
//
// Memory-port arbiter / row DMA for the Radio-86RK video path. It shares one
// synchronous memory port between the CPU and the vg75 row refresh. On a row
// request it bursts ROW_LEN consecutive screen bytes into the vg75 row buffer.
// Between bursts it serves single CPU read/write cycles. Row DMA has priority,
// but a CPU cycle that has already started always runs to completion.
//
// Ports
//   clock, reset_n          system clock (25 MHz), async active-low reset
//   base_addr, frame_start  screen base, latched on the frame pulse
//   row_req                 one-cycle request for the next text row
//   row_busy, underrun      row pending/active; sticky "request while busy"
//   cpu_req/we/addr/wdata   CPU access request, held until cpu_ready
//   cpu_rdata, cpu_ready    read data and one-cycle completion pulse
//   mem_addr/we/wdata       memory port command
//   mem_rdata               memory read data, one cycle after the address
//   buf_we/addr/data        vg75 row-buffer write port
// ----------------------------------------------------------------------------
module vt57_video_dma #(
  parameter int ROW_LEN = 78,  // bytes per row, 1..127
  parameter int ADDR_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              frame_start,
  input  logic              row_req,
  output logic              row_busy,
  output logic              underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              buf_we,
  output logic [6:0]        buf_addr,
  output logic [7:0]        buf_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_A,
    ST_CPU_D,
    ST_DMA,
    ST_DMA_LAST
  } state_t;

  localparam logic [6:0]        LAST_IDX = 7'(ROW_LEN - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_LEN);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;        // address of the next row
  logic [ADDR_W-1:0] base_q, base_d;      // base latched on frame_start
  logic [6:0]        idx_q, idx_d;        // byte index inside the burst
  logic              pending_q, pending_d;
  logic              reload_q, reload_d;  // frame reload deferred to burst end
  logic              underrun_q, underrun_d;
  logic              we_q, we_d;          // direction of the CPU cycle in flight
  logic [7:0]        rdata_q, rdata_d;
  logic              buf_we_q, buf_we_d;
  logic [6:0]        buf_addr_q, buf_addr_d;

  logic in_dma;
  logic row_accept;

  assign in_dma     = (state_q == ST_DMA) || (state_q == ST_DMA_LAST);
  assign row_busy   = pending_q || in_dma;
  assign row_accept = row_req && !row_busy;

  assign underrun  = underrun_q;
  assign cpu_ready = (state_q == ST_CPU_D);
  // Read data is forwarded in the completion cycle so it is valid alongside
  // cpu_ready, and held afterwards (writes leave it unchanged).
  assign cpu_rdata = (state_q == ST_CPU_D && !we_q) ? mem_rdata : rdata_q;
  // The buffer write lags its read by one cycle, matching memory latency.
  assign buf_we    = buf_we_q;
  assign buf_addr  = buf_addr_q;
  assign buf_data  = buf_we_q ? mem_rdata : 8'h00;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value implicitly held (which would infer a latch).
    state_d    = state_q;
    ptr_d      = ptr_q;
    base_d     = base_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    reload_d   = reload_q;
    underrun_d = underrun_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = 8'h00;

    // A new frame base must not disturb a burst already fetching; in that
    // case the pointer reload waits for the end of the burst.
    if (frame_start) begin
      base_d     = base_addr;
      underrun_d = 1'b0;
      if (in_dma) reload_d = 1'b1;
      else        ptr_d    = base_addr;
    end

    if (row_req) begin
      if (row_busy) underrun_d = 1'b1;
      else          pending_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A row request arriving this cycle blocks a CPU start, so the DMA
        // wins even when both requests show up together.
        if (pending_q) begin
          state_d = ST_DMA;
          idx_d   = 7'd0;
        end else if (!row_accept && cpu_req) begin
          state_d = ST_CPU_A;
        end
      end

      ST_CPU_A: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
        we_d      = cpu_we;
        state_d   = ST_CPU_D;
      end

      ST_CPU_D: begin
        if (!we_q) rdata_d = mem_rdata;
        state_d = ST_IDLE;
      end

      ST_DMA: begin
        mem_addr   = ptr_q + ADDR_W'(idx_q);  // wraps modulo 2^ADDR_W
        buf_we_d   = 1'b1;
        buf_addr_d = idx_q;
        if (idx_q == LAST_IDX) state_d = ST_DMA_LAST;
        else                   idx_d   = idx_q + 7'd1;
      end

      ST_DMA_LAST: begin
        pending_d = 1'b0;
        state_d   = ST_IDLE;
        if (frame_start) begin
          ptr_d    = base_addr;
          reload_d = 1'b0;
        end else if (reload_q) begin
          ptr_d    = base_q;
          reload_d = 1'b0;
        end else begin
          ptr_d = ptr_q + ROW_STEP;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      base_q     <= '0;
      idx_q      <= 7'd0;
      pending_q  <= 1'b0;
      reload_q   <= 1'b0;
      underrun_q <= 1'b0;
      we_q       <= 1'b0;
      rdata_q    <= 8'h00;
      buf_we_q   <= 1'b0;
      buf_addr_q <= 7'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      reload_q   <= reload_d;
      underrun_q <= underrun_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
    end
  end

endmodule
